alu_input_sequencer: RTL



---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu.sv | 48 ++++
 rtl/alu_input_sequencer_debouncer.sv | 44 ++++
 rtl/alu_input_sequencer.sv | 129 ++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the ALU input sequencer.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_LOAD_OP = 2'd2,
    S_SHOW    = 2'd3
  } seq_state_t;

  localparam int BTN_ENTER  = 0;
  localparam int BTN_CANCEL = 1;

  function automatic int n_chunks(input int nb_data, input int nb_sw);
    return nb_data / nb_sw;
  endfunction

  // A single-chunk operand still needs a 1-bit index port.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: arithmetic, logic and shift ops with signed overflow and zero flags.
module alu #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic [NB_DATA-1:0] i_a,
  input  logic [NB_DATA-1:0] i_b,
  input  logic [NB_OP-1:0]   i_op,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_overflow,
  output logic               o_zero
);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(32);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(34);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(36);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(37);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(38);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(39);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(3);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(2);

  localparam int MSB = NB_DATA - 1;

  always_comb begin
    o_result   = '0;
    o_overflow = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_result   = i_a + i_b;
        o_overflow = (i_a[MSB] == i_b[MSB]) && (o_result[MSB] != i_a[MSB]);
      end
      OP_SUB: begin
        o_result   = i_a - i_b;
        o_overflow = (i_a[MSB] != i_b[MSB]) && (o_result[MSB] != i_a[MSB]);
      end
      OP_AND:  o_result = i_a & i_b;
      OP_OR:   o_result = i_a | i_b;
      OP_XOR:  o_result = i_a ^ i_b;
      OP_NOR:  o_result = ~(i_a | i_b);
      OP_SRA:  o_result = $signed(i_a) >>> i_b;
      OP_SRL:  o_result = i_a >> i_b;
      default: o_result = '0;
    endcase
    o_zero = (o_result == '0);
  end

endmodule

// File: rtl/alu_input_sequencer_debouncer.sv
// Button conditioner: 2-flop sync, stability counter, stable level, registered rising-edge pulse.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] cnt;

  // The level is accepted once the synchronised input has disagreed with it for DEBOUNCE_CYCLES+1 edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
      o_pulse <= 1'b0;
    end else begin
      sync1   <= i_btn;
      sync2   <= sync1;
      level_q <= level;
      o_pulse <= level & ~level_q;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_input_sequencer.sv
// Sequenced A / B / opcode entry from debounced buttons, chunked operands, registered ALU result.
//   state     | meaning
//   S_LOAD_A  | entering operand A, one switch-width chunk per ENTER (LSB chunk first)
//   S_LOAD_B  | entering operand B, same chunking
//   S_LOAD_OP | next ENTER loads the opcode
//   S_SHOW    | result captured on first edge; ENTER starts a new entry
module alu_input_sequencer
  import alu_seq_pkg::*;
#(
  parameter int NB_SW           = 8,
  parameter int NB_DATA         = 8,
  parameter int NB_OP           = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int N_CHUNKS       = n_chunks(NB_DATA, NB_SW),
  localparam int NB_IDX         = idx_width(N_CHUNKS)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic [1:0]         i_btn,
  output logic [NB_DATA-1:0] o_result,
  output logic               o_overflow,
  output logic               o_zero,
  output logic               o_valid,
  output logic [1:0]         o_state,
  output logic [NB_IDX-1:0]  o_chunk_idx
);

  logic [1:0]         pulse;
  logic               enter_p;
  logic               cancel_p;
  seq_state_t         state;
  logic [NB_IDX-1:0]  idx;
  logic [NB_DATA-1:0] a;
  logic [NB_DATA-1:0] b;
  logic [NB_OP-1:0]   op;
  logic [NB_DATA-1:0] alu_result;
  logic               alu_overflow;
  logic               alu_zero;
  logic               last_chunk;

  for (genvar g = 0; g < 2; g++) begin : g_deb
    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_btn   (i_btn[g]),
      .o_pulse (pulse[g])
    );
  end

  assign enter_p    = pulse[BTN_ENTER];
  assign cancel_p   = pulse[BTN_CANCEL];
  assign last_chunk = (idx == NB_IDX'(N_CHUNKS - 1));

  alu #(.NB_DATA(NB_DATA), .NB_OP(NB_OP)) u_alu (
    .i_a        (a),
    .i_b        (b),
    .i_op       (op),
    .o_result   (alu_result),
    .o_overflow (alu_overflow),
    .o_zero     (alu_zero)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_LOAD_A;
      idx        <= '0;
      a          <= '0;
      b          <= '0;
      op         <= '0;
      o_result   <= '0;
      o_overflow <= 1'b0;
      o_zero     <= 1'b0;
      o_valid    <= 1'b0;
    end else if (cancel_p) begin
      state      <= S_LOAD_A;
      idx        <= '0;
      a          <= '0;
      b          <= '0;
      op         <= '0;
      o_result   <= '0;
      o_overflow <= 1'b0;
      o_zero     <= 1'b0;
      o_valid    <= 1'b0;
    end else begin
      case (state)
        S_LOAD_A: if (enter_p) begin
          a[idx*NB_SW +: NB_SW] <= i_sw;
          if (last_chunk) begin
            idx   <= '0;
            state <= S_LOAD_B;
          end else begin
            idx <= idx + NB_IDX'(1);
          end
        end
        S_LOAD_B: if (enter_p) begin
          b[idx*NB_SW +: NB_SW] <= i_sw;
          if (last_chunk) begin
            idx   <= '0;
            state <= S_LOAD_OP;
          end else begin
            idx <= idx + NB_IDX'(1);
          end
        end
        S_LOAD_OP: if (enter_p) begin
          op    <= i_sw[NB_OP-1:0];
          state <= S_SHOW;
        end
        S_SHOW: begin
          // o_valid low on entry marks the first edge here; capture once, then hold.
          if (enter_p) begin
            state   <= S_LOAD_A;
            o_valid <= 1'b0;
          end else if (!o_valid) begin
            o_result   <= alu_result;
            o_overflow <= alu_overflow;
            o_zero     <= alu_zero;
            o_valid    <= 1'b1;
          end
        end
        default: state <= S_LOAD_A;
      endcase
    end
  end

  assign o_state     = state;
  assign o_chunk_idx = idx;

endmodule
